cache_control: RTL
==================

# cache_control

Sequencing controller for the 8-set direct-mapped, write-back cache that sits between the LC-3b CPU memory port and physical memory. It decodes CPU read/write strobes against the hit/dirty status from the cache datapath. It drives write enables and mux selects for the data, tag, valid and dirty arrays. On misses it runs the write-back and line-allocate handshakes with physical memory.

## Interface
Parameters:
- PERF_W, 16, width of the optional hit/miss counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- hit  in  1  datapath: valid & tag match for indexed set (combinational)
- dirty  in  1  datapath: dirty bit of indexed set
- data_write  out  1  data array write enable
- tag_write  out  1  tag array write enable
- valid_write  out  1  valid array write enable
- dirty_write  out  1  dirty array write enable
- dirty_in  out  1  value written into dirty array
- datain_sel  out  1  0 = CPU-merged line, 1 = pmem line
- pmem_addr_sel  out  1  0 = request address, 1 = write-back address (stored tag + set)
- pmem_read  out  1  line read strobe to physical memory
- pmem_write  out  1  line write strobe to physical memory
- pmem_resp  in  1  physical memory completion, one cycle
- hit_count  out  PERF_W  hits served (CACHE_PERF_EN only)
- miss_count  out  PERF_W  misses taken (CACHE_PERF_EN only)

## Operation
- States: CHECK, WRITEBACK, ALLOCATE. All outputs are combinational from the state and inputs; the default value of every output is 0.
- CHECK, no request: idle, stay.
- CHECK, read & hit: mem_resp=1; stay.
- CHECK, write & hit: data_write=1, dirty_write=1, dirty_in=1, datain_sel=0, mem_resp=1; stay.
- CHECK, request & !hit & dirty: go to WRITEBACK. If !dirty: go to ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1. On pmem_resp, go to ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0. On the pmem_resp cycle: data_write=1, datain_sel=1, tag_write=1, valid_write=1, dirty_write=1, dirty_in=0; go to CHECK.
- After ALLOCATE, the held request re-evaluates in CHECK and hits. A write then merges and sets dirty.
- mem_read & mem_write together: treated as a write.
- Request deasserted mid-miss: protocol violation. The FSM still completes the miss, then idles in CHECK.
- pmem strobes stay asserted every cycle in their state until pmem_resp.

## Timing
- Reset (asynchronous): state = CHECK, refill flag = 0, counters = 0. All outputs go to 0 immediately.
- Reset mid-miss: the pmem strobe drops in the same cycle and no array write occurs.
- Hit latency: mem_resp in the same cycle the request is seen (0 extra cycles).
- Clean miss: mem_resp = pmem latency L + 2 cycles after the request (CHECK, L cycles ALLOCATE, CHECK).
- Dirty miss: Lw + Lr + 2 cycles.
- Array writes take effect on the rising edge closing the asserting cycle.

## Configuration
- CACHE_PERF_EN defined:
  - An internal refill flag is set on leaving CHECK for a miss and cleared on the next mem_resp.
  - miss_count increments once per CHECK→miss transition.
  - hit_count increments on each mem_resp with the refill flag clear.
  - Both counters saturate at all-ones.
- CACHE_PERF_EN undefined: no counters, no flag, and the hit_count/miss_count ports are absent.

## Structure
- The lc3b_types package gains cache_ctrl_state_t (enum CHECK/WRITEBACK/ALLOCATE). It also gains the constant CACHE_PERF_W = 16, used as the PERF_W default.
- The set index continues to use the existing lc3b_c_set.
- Sub-module sat_counter (width-parameterised, inc, saturating, async reset) is instantiated twice under CACHE_PERF_EN.

## Test plan
- Read, hit=1 → mem_resp=1 in the same cycle, no pmem strobes; hit_count=1.
- Write, hit=1 → data_write, dirty_write, dirty_in=1, mem_resp in one cycle.
- Read, hit=0, dirty=0, pmem_resp after 3 cycles:
  - pmem_read high for 3 cycles, then tag/valid/data writes with datain_sel=1.
  - mem_resp 5 cycles after the request; miss_count=1, hit_count=0.
- Write, hit=0, dirty=1:
  - pmem_write with pmem_addr_sel=1 until pmem_resp, then pmem_read.
  - Final CHECK writes with dirty_in=1.
- Reset pulsed during ALLOCATE → pmem_read drops asynchronously, state CHECK, no data_write.
- 2^16+5 hits with CACHE_PERF_EN → hit_count holds 16'hFFFF.

Source files
------------

// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b types: cache set index, cache controller state encoding and
// the default width of the controller's optional performance counters.
package lc3b_types;

  typedef logic [2:0] lc3b_c_set;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_ctrl_state_t;

  localparam int unsigned CACHE_PERF_W = 16;

endpackage

// File: rtl/cache_control_sat_counter.sv
// Up-counter that sticks at all-ones; used for the cache hit/miss statistics.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cache_control.sv
// Miss/hit sequencer for the direct-mapped write-back cache (CHECK/WRITEBACK/ALLOCATE).
// CACHE_PERF_EN adds saturating hit/miss counters and their output ports.
module cache_control
  import lc3b_types::*;
#(
  parameter int unsigned PERF_W = CACHE_PERF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  input  logic              hit,
  input  logic              dirty,
  output logic              data_write,
  output logic              tag_write,
  output logic              valid_write,
  output logic              dirty_write,
  output logic              dirty_in,
  output logic              datain_sel,
  output logic              pmem_addr_sel,
  output logic              pmem_read,
  output logic              pmem_write,
`ifdef CACHE_PERF_EN
  output logic [PERF_W-1:0] hit_count,
  output logic [PERF_W-1:0] miss_count,
`endif
  input  logic              pmem_resp
);

  if (PERF_W < 1) begin : g_bad_perf_w
    $error("cache_control: PERF_W must be at least 1");
  end

  cache_ctrl_state_t r_state;
  cache_ctrl_state_t w_next;
  logic              w_miss_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CHECK;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are forced low while reset is asserted so a reset mid-miss drops
  // the pmem strobe and blocks any array write within the same cycle.
  always_comb begin
    w_next        = r_state;
    w_miss_start  = 1'b0;
    mem_resp      = 1'b0;
    data_write    = 1'b0;
    tag_write     = 1'b0;
    valid_write   = 1'b0;
    dirty_write   = 1'b0;
    dirty_in      = 1'b0;
    datain_sel    = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    if (!reset) begin
      unique case (r_state)
        CHECK: begin
          if (mem_read || mem_write) begin
            if (hit) begin
              mem_resp = 1'b1;
              if (mem_write) begin
                data_write  = 1'b1;
                dirty_write = 1'b1;
                dirty_in    = 1'b1;
                datain_sel  = 1'b0;
              end
            end else begin
              w_miss_start = 1'b1;
              w_next       = dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) begin
            w_next = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = 1'b0;
          if (pmem_resp) begin
            data_write  = 1'b1;
            datain_sel  = 1'b1;
            tag_write   = 1'b1;
            valid_write = 1'b1;
            dirty_write = 1'b1;
            dirty_in    = 1'b0;
            w_next      = CHECK;
          end
        end
        default: begin
          w_next = CHECK;
        end
      endcase
    end
  end

`ifdef CACHE_PERF_EN
  // Marks the response that completes a miss so it is not also counted as a hit.
  logic r_refill;
  logic w_hit_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refill <= 1'b0;
    end else if (w_miss_start) begin
      r_refill <= 1'b1;
    end else if (mem_resp) begin
      r_refill <= 1'b0;
    end
  end

  assign w_hit_inc = mem_resp && !r_refill;

  sat_counter #(.W(PERF_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(PERF_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_miss_start),
    .count (miss_count)
  );
`else
  logic w_unused_miss;
  assign w_unused_miss = w_miss_start;
`endif

endmodule
